// File: rtl/chacha_block_core_if.sv
// Handshake bundle for chacha_block_core: the initial matrix goes in and the finished keystream block comes out.
// Matrices are [row][col] of 32-bit words; word (r,c) sits at bit offset (r*4+c)*32.
interface chacha_block_core_if;
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0][3:0][31:0]  state_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [3:0][3:0][31:0]  keystream;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, keystream
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, keystream
  );
endinterface

// File: rtl/chacha_block_core.sv
// ChaCha block function core: DOUBLE_ROUNDS double rounds, then feed-forward add, with a valid/ready handshake.
// Define CHACHA_QR_SERIAL_EN to use one shared quarter-round unit (4 cycles per half-round) instead of four.
module chacha_block_core #(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  chacha_block_core_if.slave  bus
);

  typedef logic [31:0]    word_t;
  typedef word_t [15:0]   matrix_t;
  typedef struct packed { word_t a, b, c, d; } qr_t;
  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_e;

  localparam logic [4:0] LAST_HR = 5'(2 * DOUBLE_ROUNDS - 1);

  function automatic word_t rotl(word_t x, int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic qr_t quarter_round(qr_t q);
    q.a = q.a + q.b; q.d = rotl(q.d ^ q.a, 16);
    q.c = q.c + q.d; q.b = rotl(q.b ^ q.c, 12);
    q.a = q.a + q.b; q.d = rotl(q.d ^ q.a, 8);
    q.c = q.c + q.d; q.b = rotl(q.b ^ q.c, 7);
    return q;
  endfunction

  // Quarter-round i of a column (diag=0) or diagonal (diag=1) half-round; row r offsets the column by r*diag.
  function automatic matrix_t apply_qr(matrix_t m, logic [1:0] i, logic diag);
    logic [3:0] ia, ib, ic, id;
    qr_t        r;
    ia = {2'b00, i};
    ib = {2'b01, i + {1'b0, diag}};
    ic = {2'b10, i + {diag, 1'b0}};
    id = {2'b11, i + {diag, diag}};
    r  = quarter_round(qr_t'({m[ia], m[ib], m[ic], m[id]}));
    m[ia] = r.a;
    m[ib] = r.b;
    m[ic] = r.c;
    m[id] = r.d;
    return m;
  endfunction

`ifndef CHACHA_QR_SERIAL_EN
  // The four quarter-rounds of a half-round touch disjoint words, so chaining them equals running them in parallel.
  function automatic matrix_t half_round(matrix_t m, logic diag);
    for (int i = 0; i < 4; i++) m = apply_qr(m, 2'(i), diag);
    return m;
  endfunction
`endif

  state_e   state_q, state_d;
  logic [4:0] round_q, round_d;
  matrix_t  work_q, work_d;
  matrix_t  ff_q, ff_d;
  matrix_t  ks_q, ks_d;
  logic     out_valid_q, out_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     hr_done;
`ifdef CHACHA_QR_SERIAL_EN
  logic [1:0] qr_idx_q, qr_idx_d;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    work_d      = work_q;
    ff_d        = ff_q;
    ks_d        = ks_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    hr_done     = 1'b0;
`ifdef CHACHA_QR_SERIAL_EN
    qr_idx_d    = qr_idx_q;
`endif

    if (abort) begin
      state_d     = IDLE;
      round_d     = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
`ifdef CHACHA_QR_SERIAL_EN
      qr_idx_d    = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            work_d     = bus.state_in;
            ff_d       = bus.state_in;
            round_d    = '0;
            in_ready_d = 1'b0;
            state_d    = (DOUBLE_ROUNDS == 0) ? ADD : ROUND;
`ifdef CHACHA_QR_SERIAL_EN
            qr_idx_d   = '0;
`endif
          end
        end
        ROUND: begin
          // Even counts are column half-rounds, odd counts diagonal.
`ifdef CHACHA_QR_SERIAL_EN
          work_d   = apply_qr(work_q, qr_idx_q, round_q[0]);
          qr_idx_d = qr_idx_q + 2'd1;
          hr_done  = (qr_idx_q == 2'd3);
`else
          work_d   = half_round(work_q, round_q[0]);
          hr_done  = 1'b1;
`endif
          if (hr_done) begin
            if (round_q == LAST_HR) begin
              round_d = '0;
              state_d = ADD;
            end else begin
              round_d = round_q + 5'd1;
            end
          end
        end
        ADD: begin
          for (int i = 0; i < 16; i++) ks_d[i] = work_q[i] + ff_q[i];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      // NOTE: the matrices are reset too, so no key material survives a reset.
      work_q      <= '0;
      ff_q        <= '0;
      ks_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef CHACHA_QR_SERIAL_EN
      qr_idx_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      work_q      <= work_d;
      ff_q        <= ff_d;
      ks_q        <= ks_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef CHACHA_QR_SERIAL_EN
      qr_idx_q    <= qr_idx_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core: RFC 8439 reference model plus directed handshake, abort and reset vectors.
module tb_chacha_block_core;

  localparam int DR = 10;
`ifdef CHACHA_QR_SERIAL_EN
  localparam int LAT = 8 * DR + 1;
`else
  localparam int LAT = 2 * DR + 1;
`endif

  typedef logic [31:0] wa_t [16];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic abort0 = 1'b0;
  int   total = 0;
  int   bad = 0;

  chacha_block_core_if bus ();
  chacha_block_core_if bus0 ();

  chacha_block_core #(.DOUBLE_ROUNDS(DR)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus)
  );
  chacha_block_core #(.DOUBLE_ROUNDS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort0), .bus(bus0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: RFC 8439 block function ----------------
  function automatic logic [31:0] rol(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic wa_t qr(wa_t x, int a, int b, int c, int d);
    x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
    x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
    x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
    x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
    return x;
  endfunction

  function automatic logic [511:0] ref_block(logic [511:0] s, int dr);
    wa_t x;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = s[i*32 +: 32];
    for (int k = 0; k < dr; k++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = x[i] + s[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [511:0] pack(wa_t w);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  // ---------------- transaction-level model of the handshake ----------------
  logic         m_busy, m_ov;
  int           m_cnt;
  logic [511:0] m_ks, m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ov <= 1'b0; m_cnt <= 0; m_ks <= '0;
    end else if (abort) begin
      m_busy <= 1'b0; m_ov <= 1'b0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
        m_exp  <= ref_block(bus.state_in, DR);
      end
    end else if (m_ov) begin
      if (bus.out_ready) begin
        m_busy <= 1'b0; m_ov <= 1'b0;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ov <= 1'b1;
        m_ks <= m_exp;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_out_valid", 512'(bus.out_valid), 512'(m_ov));
      check("cyc_in_ready", 512'(bus.in_ready), 512'(!m_busy));
      check("cyc_keystream", bus.keystream, m_ks);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [511:0] v);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("send_ready", 512'(bus.in_ready), 512'(1));
    bus.in_valid = 1'b1;
    bus.state_in = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int n);
    n = start;
    while (!bus.out_valid && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  wa_t rfc_w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                 32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                 32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                 32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  wa_t exp_w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                 32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                 32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                 32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  initial begin
    logic [511:0] rfc, rfc_exp, ones, ctr2;
    int n;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;  bus.state_in = '0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.state_in = '0;
    rfc     = pack(rfc_w);
    rfc_exp = pack(exp_w);
    ones    = '1;

    check("model_rfc", ref_block(rfc, 10), rfc_exp);
    check("model_dr0", ref_block(ones, 0), {16{32'hfffffffe}});

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 512'(bus.in_ready), 512'(1));
    check("rst_out_valid", 512'(bus.out_valid), 512'(0));
    check("rst_keystream", bus.keystream, '0);
    check("rst_in_ready0", 512'(bus0.in_ready), 512'(1));

    // RFC block with in_valid noise during ROUND, then a 10-clock consumer stall
    send(rfc);
    bus.in_valid = 1'b1; bus.state_in = ~rfc;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(3, n);
    check("latency_rfc", 512'(n), 512'(LAT));
    check("ks_rfc", bus.keystream, rfc_exp);
    repeat (10) @(posedge clk);
    #1;
    check("hold_ks", bus.keystream, rfc_exp);
    check("hold_in_ready", 512'(bus.in_ready), 512'(0));
    check("hold_out_valid", 512'(bus.out_valid), 512'(1));
    take();
    check("drain_out_valid", 512'(bus.out_valid), 512'(0));
    check("drain_in_ready", 512'(bus.in_ready), 512'(1));

    // in_valid together with abort in IDLE is not accepted
    bus.in_valid = 1'b1; bus.state_in = rfc; abort = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_ready", 512'(bus.in_ready), 512'(1));

    // abort at clock 7 of ROUND, then a clean block
    send(rfc);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 512'(bus.in_ready), 512'(1));
    check("abort_out_valid", 512'(bus.out_valid), 512'(0));
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("abort_no_out", 512'(bus.out_valid), 512'(0));
    send(rfc);
    wait_out(0, n);
    check("latency_after_abort", 512'(n), 512'(LAT));
    check("ks_after_abort", bus.keystream, rfc_exp);
    take();

    // a second block (counter = 2) checked through the model
    ctr2 = rfc;
    ctr2[12*32 +: 32] = 32'd2;
    send(ctr2);
    wait_out(0, n);
    check("latency_ctr2", 512'(n), 512'(LAT));
    check("ks_ctr2", bus.keystream, ref_block(ctr2, DR));
    take();

    // asynchronous reset mid-ROUND
    send(rfc);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 512'(bus.out_valid), 512'(0));
    check("arst_keystream", bus.keystream, '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_in_ready", 512'(bus.in_ready), 512'(1));
    check("arst_no_out", 512'(bus.out_valid), 512'(0));

    // zero-round instance: output one clock after accept
    bus0.in_valid = 1'b1; bus0.state_in = ones;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    check("dr0_not_yet", 512'(bus0.out_valid), 512'(0));
    check("dr0_busy", 512'(bus0.in_ready), 512'(0));
    @(posedge clk); #1;
    check("dr0_out_valid", 512'(bus0.out_valid), 512'(1));
    check("dr0_keystream", bus0.keystream, {16{32'hfffffffe}});
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    check("dr0_drain", 512'(bus0.in_ready), 512'(1));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chacha_block_core.md
CHACHA_BLOCK_CORE -- requirements
Module: chacha_block_core

Interface
REQ-001 SHALL have parameter DOUBLE_ROUNDS, default 10, number of column+diagonal round pairs (0..15 legal).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port abort  input  1  synchronous discard of any in-flight block.
REQ-005 SHALL have port in_valid  input  1  state_in holds a valid initial ChaCha matrix.
REQ-006 SHALL have port in_ready  output  1  core can accept a matrix.
REQ-007 SHALL have port state_in  input  16x32 (word_t [3:0][3:0], [row][col])  initial matrix from the matrix builder: constants, key, block counter, nonce.
REQ-008 SHALL have port out_valid  output  1  keystream holds a finished block.
REQ-009 SHALL have port out_ready  input  1  consumer accepts keystream.
REQ-010 SHALL have port keystream  output  16x32 (word_t [3:0][3:0])  block function result.

Function
REQ-011 SHALL implement FSM states IDLE, ROUND, ADD, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready the core SHALL capture state_in into both the working matrix and the feed-forward copy, then go to ROUND (or to ADD if DOUBLE_ROUNDS=0).
REQ-013 ROUND: each cycle SHALL perform one half-round, 4 quarter-rounds in parallel; odd cycles are column rounds (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15); even cycles are diagonal rounds (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14), using row-major word index.
REQ-014 Quarter-round SHALL be: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7, with all additions mod 2^32.
REQ-015 A round counter SHALL count 2*DOUBLE_ROUNDS half-rounds; after the last one the FSM SHALL go to ADD.
REQ-016 ADD: SHALL register keystream = working + feed-forward copy, word-wise mod 2^32, set out_valid, and go to DONE.
REQ-017 Latency: with accept at edge E0, keystream and out_valid SHALL be updated at edge E(2*DOUBLE_ROUNDS+1), i.e. 21 clocks at the default.
REQ-018 DONE: out_valid=1 and keystream SHALL be held stable until out_valid&&out_ready, then out_valid=0 and the FSM goes to IDLE.
REQ-019 in_ready SHALL be 0 in ROUND, ADD and DONE; in_valid in those states SHALL be ignored.
REQ-020 abort=1 SHALL, at the next edge and from any state, force IDLE, out_valid=0 and the round counter to 0; keystream retains its value; abort has priority over all handshakes in the same cycle.
REQ-021 in_valid and abort asserted together in IDLE SHALL not accept the matrix.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, round counter=0, out_valid=0, keystream=0, working and feed-forward matrices=0; in_ready=1 while in IDLE after reset.
REQ-023 Reset asserted mid-block SHALL discard the block with no output handshake.

Configuration
REQ-024 Macro CHACHA_QR_SERIAL_EN: when defined, the core SHALL instantiate one quarter-round unit and perform one quarter-round per ROUND cycle, in the REQ-013 order (4 cycles per half-round), for latency 8*DOUBLE_ROUNDS+1 clocks (81 at default).
REQ-025 Without CHACHA_QR_SERIAL_EN, the core SHALL use 4 parallel quarter-round units per REQ-013/REQ-017; the keystream SHALL be identical in both builds.

Verification
REQ-026 Drive RFC 8439 2.3.2 matrix (key 00..1f, counter 1, nonce 000000090000004a00000000) -> keystream words 0..15 = e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2, out_valid at clock 21 (81 serial).
REQ-027 DOUBLE_ROUNDS=0, all words 0xFFFFFFFF -> out_valid 1 clock after accept, every keystream word 0xFFFFFFFE.
REQ-028 Hold out_ready=0 for 10 clocks after out_valid -> keystream stable, in_ready=0, out_valid=1; out_ready=1 -> IDLE next clock, in_ready=1.
REQ-029 Assert abort at clock 7 of ROUND -> out_valid never rises, in_ready=1 next clock; next RFC vector completes correctly.
REQ-030 Pulse rst_n low mid-ROUND, asynchronous to clk -> out_valid=0 and keystream=0 immediately; in_ready=1 after release.
